// File: rtl/hs32_decode_q_pkg.sv
// Shared hs32 decode definitions: opcode classes, memory sub-ops, ALU codes,
// control-signal bit indices, instruction field positions and the decoded-field bundle.
package hs32_decode_q_pkg;

    localparam logic [3:0] CLS_ALU_RR = 4'h0;
    localparam logic [3:0] CLS_ALU_RI = 4'h1;
    localparam logic [3:0] CLS_MEM    = 4'h2;

    localparam logic [3:0] MEM_LDRI = 4'h0;
    localparam logic [3:0] MEM_LDR  = 4'h1;
    localparam logic [3:0] MEM_LDRA = 4'h2;
    localparam logic [3:0] MEM_STRI = 4'h4;
    localparam logic [3:0] MEM_STR  = 4'h5;
    localparam logic [3:0] MEM_STRA = 4'h6;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_BIC = 3'd5,
        ALU_MOV = 3'd6,
        ALU_CMP = 3'd7
    } aluop_t;

    localparam int CTL_LEGAL = 0;
    localparam int CTL_IMM   = 1;
    localparam int CTL_RNSH  = 2;
    localparam int CTL_MRD   = 3;
    localparam int CTL_MWR   = 4;
    localparam int CTL_WB    = 5;
    localparam int CTL_FLAG  = 6;

    localparam int RD_LSB  = 20;
    localparam int RM_LSB  = 16;
    localparam int RN_LSB  = 12;
    localparam int SH_LSB  = 7;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic        illegal;
        logic [15:0] ctlsig;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rn;
        logic [4:0]  shift;
        aluop_t      aluop;
    } dec_fields_t;

endpackage

// File: rtl/hs32_decode_fifo.sv
// Generic WIDTH x DEPTH synchronous queue; pop_data shows the head entry combinationally.
// Push is ignored when full and pop when empty; DEPTH must be a power of two >= 2.
module hs32_decode_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hs32_decode_q.sv
// Queued hs32 decode stage: 1-cycle latency, fetch is stalled only when the DEPTH-entry queue is full.
// HS32_DECODE_ILLEGAL_EN: enqueue illegal words flagged for trapping; otherwise they are silently dropped.
module hs32_decode_q
    import hs32_decode_q_pkg::*;
#(
    parameter int IW    = 32,
    parameter int DEPTH = 2,
    parameter int XW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instd,
    input  logic          ackd,
    output logic          reqd,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [2:0]    aluop,
    output logic [4:0]    shift,
    output logic [XW-1:0] imm,
    output logic [3:0]    rd,
    output logic [3:0]    rm,
    output logic [3:0]    rn,
    output logic [15:0]   ctlsig,
    output logic          illegal
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        dec_fields_t   f;
        logic [XW-1:0] imm;
    } bundle_t;

    function automatic bundle_t decode(input logic [IW-1:0] w);
        bundle_t     b;
        logic [7:0]  op;
        logic [15:0] imm16;
        logic        legal;
        b      = '0;
        op     = w[IW-1 -: 8];
        imm16  = w[IMM_LSB +: 16];
        legal  = 1'b0;
        b.f.rd = w[RD_LSB +: 4];
        b.f.rm = w[RM_LSB +: 4];
        case (op[7:4])
            CLS_ALU_RR, CLS_ALU_RI: begin
                legal          = !op[3];
                b.f.aluop      = aluop_t'(op[2:0]);
                b.f.ctlsig[CTL_WB]   = (b.f.aluop != ALU_CMP);
                b.f.ctlsig[CTL_FLAG] = (b.f.aluop == ALU_CMP) || (b.f.aluop == ALU_SUB);
                if (op[7:4] == CLS_ALU_RR) begin
                    b.f.rn    = w[RN_LSB +: 4];
                    b.f.shift = w[SH_LSB +: 5];
                    b.f.ctlsig[CTL_RNSH] = 1'b1;
                end else begin
                    b.imm = XW'(imm16);
                    b.f.ctlsig[CTL_IMM] = 1'b1;
                end
            end
            CLS_MEM: begin
                b.f.aluop = ALU_ADD;
                legal     = 1'b1;
                case (op[3:0])
                    MEM_LDRI, MEM_STRI: begin
                        b.imm = XW'($signed(imm16));
                        b.f.ctlsig[CTL_IMM] = 1'b1;
                    end
                    MEM_LDRA, MEM_STRA: begin
                        b.f.rn    = w[RN_LSB +: 4];
                        b.f.shift = w[SH_LSB +: 5];
                        b.f.ctlsig[CTL_RNSH] = 1'b1;
                    end
                    MEM_LDR, MEM_STR: ;
                    default: legal = 1'b0;
                endcase
                // Sub-op bit 2 selects store vs load.
                b.f.ctlsig[CTL_MRD] = !op[2];
                b.f.ctlsig[CTL_MWR] = op[2];
                b.f.ctlsig[CTL_WB]  = !op[2];
            end
            default: legal = 1'b0;
        endcase
        if (legal) begin
            b.f.ctlsig[CTL_LEGAL] = 1'b1;
        end else begin
            b = '0;
            b.f.illegal = 1'b1;
        end
        return b;
    endfunction

    bundle_t       dec;
    bundle_t       head_raw;
    bundle_t       last_q;
    bundle_t       head;
    bundle_t       shown;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    assign dec     = decode(instd);
    assign reqd    = !full && !reset;
    assign valid_o = !empty && !reset;
    assign pop     = valid_o && ready_i;

`ifdef HS32_DECODE_ILLEGAL_EN
    assign push = ackd && reqd;
`else
    assign push = ackd && reqd && dec.f.ctlsig[CTL_LEGAL];
`endif

    hs32_decode_fifo #(
        .WIDTH ($bits(bundle_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (dec),
        .pop       (pop),
        .pop_data  (head_raw),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Once drained, keep presenting the last popped bundle rather than a stale slot.
    always_ff @(posedge clk) begin
        if (reset)    last_q <= '0;
        else if (pop) last_q <= head_raw;
    end

    assign head  = empty ? last_q : head_raw;
    assign shown = reset ? '0 : head;

    assign aluop  = shown.f.aluop;
    assign shift  = shown.f.shift;
    assign imm    = shown.imm;
    assign rd     = shown.f.rd;
    assign rm     = shown.f.rm;
    assign rn     = shown.f.rn;
    assign ctlsig = shown.f.ctlsig;

`ifdef HS32_DECODE_ILLEGAL_EN
    assign illegal = shown.f.illegal;
`else
    assign illegal = 1'b0;
    a_no_illegal_queued: assert property (@(posedge clk) disable iff (reset)
        !(valid_o && head.f.illegal));
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= CW'(DEPTH));

endmodule

// File: tb/tb_hs32_decode_q.sv
// Directed and randomised self-checking bench for hs32_decode_q at DEPTH=2.
// Honours HS32_DECODE_ILLEGAL_EN the same way the design does.
module tb_hs32_decode_q;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instd = '0;
    logic        ackd = 1'b0;
    logic        reqd;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [2:0]  aluop;
    logic [4:0]  shift;
    logic [31:0] imm;
    logic [3:0]  rd, rm, rn;
    logic [15:0] ctlsig;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    hs32_decode_q #(.IW(32), .DEPTH(DEPTH), .XW(32)) dut (
        .clk(clk), .reset(reset), .instd(instd), .ackd(ackd), .reqd(reqd),
        .valid_o(valid_o), .ready_i(ready_i), .aluop(aluop), .shift(shift),
        .imm(imm), .rd(rd), .rm(rm), .rn(rn), .ctlsig(ctlsig), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ill;
        logic [2:0]  aluop;
        logic [4:0]  shift;
        logic [31:0] imm;
        logic [3:0]  rd, rm, rn;
        logic [15:0] ctl;
    } exp_t;

    function automatic exp_t model(input logic [31:0] w);
        exp_t       e;
        logic [3:0] cls, sub;
        e   = '0;
        cls = w[31:28];
        sub = w[27:24];
        if ((cls == 4'h0 || cls == 4'h1) && !sub[3]) begin
            e.aluop = sub[2:0];
            e.rd = w[23:20];
            e.rm = w[19:16];
            if (cls == 4'h0) begin
                e.rn = w[15:12]; e.shift = w[11:7]; e.ctl = 16'h0005;
            end else begin
                e.imm = {16'h0, w[15:0]}; e.ctl = 16'h0003;
            end
            if (sub[2:0] != 3'd7) e.ctl = e.ctl | 16'h0020;
            if (sub[2:0] == 3'd7 || sub[2:0] == 3'd1) e.ctl = e.ctl | 16'h0040;
        end else if (cls == 4'h2) begin
            e.rd = w[23:20];
            e.rm = w[19:16];
            case (sub)
                4'h0: begin e.imm = {{16{w[15]}}, w[15:0]}; e.ctl = 16'h002B; end
                4'h1: e.ctl = 16'h0029;
                4'h2: begin e.rn = w[15:12]; e.shift = w[11:7]; e.ctl = 16'h002D; end
                4'h4: begin e.imm = {{16{w[15]}}, w[15:0]}; e.ctl = 16'h0013; end
                4'h5: e.ctl = 16'h0011;
                4'h6: begin e.rn = w[15:12]; e.shift = w[11:7]; e.ctl = 16'h0015; end
                default: e.ill = 1'b1;
            endcase
        end else begin
            e.ill = 1'b1;
        end
        if (e.ill) begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1; ackd = 1'b0; ready_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({reqd, valid_o, illegal} !== 3'b000) begin
            failures++;
            $display("FAIL reset_hs got reqd/valid/illegal=%b exp 000", {reqd, valid_o, illegal});
        end
        checks++;
        if ({aluop, shift, imm, rd, rm, rn, ctlsig} !== '0) begin
            failures++;
            $display("FAIL reset_fields got ctl=%h rd=%h imm=%h exp all zero", ctlsig, rd, imm);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({reqd, valid_o} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release got reqd/valid=%b exp 10", {reqd, valid_o});
        end
    endtask

    task automatic test_ldr();
        @(negedge clk);
        instd = 32'h21A5FFFC; ackd = 1'b1; ready_i = 1'b1;
        @(negedge clk);
        ackd = 1'b0;
        checks++;
        if ({valid_o, aluop, rd, rm, rn, shift, imm, ctlsig} !==
            {1'b1, 3'd0, 4'hA, 4'h5, 4'h0, 5'd0, 32'h0, 16'h0029}) begin
            failures++;
            $display("FAIL ldr got v=%b alu=%h rd=%h rm=%h rn=%h sh=%h imm=%h ctl=%h exp v=1 alu=0 rd=a rm=5 rn=0 sh=0 imm=0 ctl=0029",
                     valid_o, aluop, rd, rm, rn, shift, imm, ctlsig);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL ldr_drain got valid=%b exp 0", valid_o);
        end
    endtask

    task automatic test_imm_ext();
        logic [31:0] w[2]    = '{32'h20310FF0, 32'h2031FFF0};
        logic [31:0] eimm[2] = '{32'h00000FF0, 32'hFFFFFFF0};
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instd = w[i]; ackd = 1'b1;
            @(negedge clk);
            checks++;
            if ({valid_o, imm, rd, rm, ctlsig} !== {1'b1, eimm[i], 4'h3, 4'h1, 16'h002B}) begin
                failures++;
                $display("FAIL ldri_imm%0d got v=%b imm=%h rd=%h rm=%h ctl=%h exp v=1 imm=%h rd=3 rm=1 ctl=002b",
                         i, valid_o, imm, rd, rm, ctlsig, eimm[i]);
            end
        end
        ackd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        logic [31:0] w[5]    = '{32'h01123480, 32'h07450000, 32'h1389ABCD, 32'h2612F080, 32'h24567FFF};
        logic [2:0]  ea[5]   = '{3'd1, 3'd7, 3'd3, 3'd0, 3'd0};
        logic [3:0]  erd[5]  = '{4'h1, 4'h4, 4'h8, 4'h1, 4'h5};
        logic [3:0]  erm[5]  = '{4'h2, 4'h5, 4'h9, 4'h2, 4'h6};
        logic [3:0]  ern[5]  = '{4'h3, 4'h0, 4'h0, 4'hF, 4'h0};
        logic [4:0]  esh[5]  = '{5'd9, 5'd0, 5'd0, 5'd1, 5'd0};
        logic [31:0] eim[5]  = '{32'h0, 32'h0, 32'h0000ABCD, 32'h0, 32'h00007FFF};
        logic [15:0] ec[5]   = '{16'h0065, 16'h0045, 16'h0023, 16'h0015, 16'h0013};
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instd = w[i]; ackd = 1'b1;
            @(negedge clk);
            checks++;
            if ({valid_o, aluop, rd, rm, rn, shift, imm, ctlsig} !==
                {1'b1, ea[i], erd[i], erm[i], ern[i], esh[i], eim[i], ec[i]}) begin
                failures++;
                $display("FAIL decode_vec%0d got alu=%h rd=%h rm=%h rn=%h sh=%h imm=%h ctl=%h exp alu=%h rd=%h rm=%h rn=%h sh=%h imm=%h ctl=%h",
                         i, aluop, rd, rm, rn, shift, imm, ctlsig, ea[i], erd[i], erm[i], ern[i], esh[i], eim[i], ec[i]);
            end
        end
        ackd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b0;
        instd = 32'h00100000; ackd = 1'b1;
        @(negedge clk);
        checks++;
        if ({reqd, valid_o, rd} !== {1'b1, 1'b1, 4'h1}) begin
            failures++;
            $display("FAIL bp_first got reqd=%b v=%b rd=%h exp 1 1 1", reqd, valid_o, rd);
        end
        instd = 32'h00200000;
        @(negedge clk);
        instd = 32'h00300000;
        checks++;
        if ({reqd, valid_o, rd} !== {1'b0, 1'b1, 4'h1}) begin
            failures++;
            $display("FAIL bp_full got reqd=%b v=%b rd=%h exp 0 1 1", reqd, valid_o, rd);
        end
        @(negedge clk);
        checks++;
        if ({reqd, rd} !== {1'b0, 4'h1}) begin
            failures++;
            $display("FAIL bp_hold got reqd=%b rd=%h exp 0 1", reqd, rd);
        end
        ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({reqd, valid_o, rd} !== {1'b1, 1'b1, 4'h2}) begin
            failures++;
            $display("FAIL bp_second got reqd=%b v=%b rd=%h exp 1 1 2", reqd, valid_o, rd);
        end
        @(negedge clk);
        ackd = 1'b0;
        checks++;
        if ({valid_o, rd} !== {1'b1, 4'h3}) begin
            failures++;
            $display("FAIL bp_third got v=%b rd=%h exp 1 3", valid_o, rd);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_drained got valid=%b exp 0", valid_o);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] w[3] = '{32'hF0000000, 32'h08123456, 32'h23000000};
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instd = w[i]; ackd = 1'b1;
            #1;
            checks++;
            if (reqd !== 1'b1) begin
                failures++;
                $display("FAIL ill_reqd%0d got %b exp 1", i, reqd);
            end
            @(negedge clk);
            ackd = 1'b0;
            checks++;
`ifdef HS32_DECODE_ILLEGAL_EN
            if ({valid_o, illegal, ctlsig, rd, rm, imm} !== {1'b1, 1'b1, 16'h0, 4'h0, 4'h0, 32'h0}) begin
                failures++;
                $display("FAIL ill_bundle%0d got v=%b ill=%b ctl=%h rd=%h imm=%h exp v=1 ill=1 rest 0",
                         i, valid_o, illegal, ctlsig, rd, imm);
            end
`else
            if ({valid_o, reqd, illegal} !== 3'b010) begin
                failures++;
                $display("FAIL ill_drop%0d got v/reqd/ill=%b exp 010", i, {valid_o, reqd, illegal});
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        ready_i = 1'b0;
        instd = 32'h00100000; ackd = 1'b1;
        @(negedge clk);
        instd = 32'h00200000;
        @(negedge clk);
        reset = 1'b1; instd = 32'h00500000;
        #1;
        checks++;
        if ({reqd, valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset_during got reqd/valid=%b exp 00", {reqd, valid_o});
        end
        @(negedge clk);
        reset = 1'b0; ackd = 1'b0;
        #1;
        checks++;
        if ({reqd, valid_o, rd, ctlsig} !== {1'b1, 1'b0, 4'h0, 16'h0}) begin
            failures++;
            $display("FAIL mid_reset_after got reqd=%b v=%b rd=%h ctl=%h exp 1 0 0 0", reqd, valid_o, rd, ctlsig);
        end
        @(negedge clk);
        instd = 32'h21A5FFFC; ackd = 1'b1; ready_i = 1'b1;
        @(negedge clk);
        ackd = 1'b0;
        checks++;
        if ({valid_o, rd, rm, ctlsig} !== {1'b1, 4'hA, 4'h5, 16'h0029}) begin
            failures++;
            $display("FAIL mid_reset_next got v=%b rd=%h rm=%h ctl=%h exp 1 a 5 0029", valid_o, rd, rm, ctlsig);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_stale got valid=%b exp 0", valid_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] rnd;
        logic [3:0]  cls;
        exp_t        e;
        int          sz;
        int          pr;
        bit          lim_fail;
        lim_fail = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            sz = q.size();
            if (sz > DEPTH && !lim_fail) begin
                lim_fail = 1'b1;
                failures++;
                $display("FAIL rnd_model_depth got %0d exp <= %0d", sz, DEPTH);
            end
            checks++;
            if ({valid_o, reqd} !== {sz > 0, sz < DEPTH}) begin
                failures++;
                $display("FAIL rnd_hs cyc=%0d got v/reqd=%b exp %b", cyc, {valid_o, reqd}, {sz > 0, sz < DEPTH});
            end
            if (sz > 0) begin
                e = model(q[0]);
                checks++;
                if ({illegal, aluop, shift, imm, rd, rm, rn, ctlsig} !== e) begin
                    failures++;
                    $display("FAIL rnd_head cyc=%0d word=%h got ill=%b alu=%h sh=%h imm=%h rd=%h rm=%h rn=%h ctl=%h exp %h",
                             cyc, q[0], illegal, aluop, shift, imm, rd, rm, rn, ctlsig, e);
                end
            end
            pr  = ((cyc / 500) % 2 == 0) ? 80 : 25;
            rnd = $urandom();
            case ($urandom_range(0, 7))
                0, 1:    cls = 4'h0;
                2, 3:    cls = 4'h1;
                4, 5:    cls = 4'h2;
                default: cls = 4'($urandom_range(0, 15));
            endcase
            instd   = {cls, rnd[27:0]};
            ackd    = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 99) < pr);
            e = model(instd);
            if (ready_i && sz > 0) void'(q.pop_front());
`ifdef HS32_DECODE_ILLEGAL_EN
            if (ackd && sz < DEPTH) q.push_back(instd);
`else
            if (ackd && sz < DEPTH && !e.ill) q.push_back(instd);
`endif
            @(negedge clk);
        end
        ackd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_imm_ext();
        test_alu();
        test_back_to_back();
        test_illegal();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
